// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned INSTR_W         = 32;
    localparam int unsigned ROM_LAT_DEFAULT = 1;

    localparam logic PC_SEL_SEQ = 1'b0;
    localparam logic PC_SEL_BR  = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StValid,
        StHalted
    } fetch_state_e;

    // Counter width able to hold the value lat (at least one bit).
    function automatic int unsigned lat_cnt_w(input int unsigned lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-sequencer bus: control inputs, decode handshake and IF-stage PC controls.
// Fetch_cnt (and CNT_W) exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_ctrl_if
`ifdef FETCH_PERF_CNT_EN
    #(parameter int unsigned CNT_W = 16)
`endif
    ();

    logic                         Start;
    logic                         Halt;
    logic [fetch_pkg::INSTR_W-1:0] Instr_in;
    logic                         Instr_ready;
    logic                         Branch_taken;
    logic [fetch_pkg::INSTR_W-1:0] Instr_out;
    logic                         Instr_valid;
    logic                         PC_LdEn;
    logic                         PC_sel;
    logic                         Busy;
`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0]             Fetch_cnt;
`endif

    // Environment side: ROM, decode and pipeline control.
    modport master (
        output Start, Halt, Instr_in, Instr_ready, Branch_taken,
        input  Instr_out, Instr_valid, PC_LdEn, PC_sel, Busy
`ifdef FETCH_PERF_CNT_EN
        , input Fetch_cnt
`endif
    );

    // Sequencer side.
    modport slave (
        input  Start, Halt, Instr_in, Instr_ready, Branch_taken,
        output Instr_out, Instr_valid, PC_LdEn, PC_sel, Busy
`ifdef FETCH_PERF_CNT_EN
        , output Fetch_cnt
`endif
    );

endinterface

// File: rtl/fetch_lat_cnt.sv
// Loadable down-counter that times out the synchronous ROM read latency.
module fetch_lat_cnt
    import fetch_pkg::*;
#(
    parameter int unsigned ROM_LAT = ROM_LAT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic dec_i,
    output logic last_o
);

    localparam int unsigned CntW = lat_cnt_w(ROM_LAT);
    localparam logic [CntW-1:0] LoadVal = CntW'(ROM_LAT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LoadVal;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one instruction in flight, PC advances on decode handshake.
// Optional retired-fetch counter enabled by FETCH_PERF_CNT_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ROM_LAT = ROM_LAT_DEFAULT
`ifdef FETCH_PERF_CNT_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic        Clk,
    input  logic        Reset,
    fetch_ctrl_if.slave bus
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               halt_pend_q, halt_pend_d;

    logic lat_load;
    logic lat_dec;
    logic lat_last;
    logic handshake;
    logic instr_valid;
    logic pc_ld_en;
    logic pc_sel;

    fetch_lat_cnt #(
        .ROM_LAT(ROM_LAT)
    ) u_lat_cnt (
        .clk_i (Clk),
        .rst_ni(Reset),
        .load_i(lat_load),
        .dec_i (lat_dec),
        .last_o(lat_last)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        halt_pend_d = halt_pend_q;
        lat_load    = 1'b0;
        lat_dec     = 1'b0;
        handshake   = 1'b0;
        instr_valid = 1'b0;
        pc_ld_en    = 1'b0;
        pc_sel      = PC_SEL_SEQ;

        unique case (state_q)
            StIdle, StHalted: begin
                // A Halt arriving with Start lets exactly one instruction through.
                if (bus.Start) begin
                    state_d     = StWait;
                    lat_load    = 1'b1;
                    halt_pend_d = bus.Halt;
                end
            end
            StWait: begin
                lat_dec     = 1'b1;
                halt_pend_d = halt_pend_q | bus.Halt;
                if (lat_last) begin
                    ir_d    = bus.Instr_in;
                    state_d = StValid;
                end
            end
            StValid: begin
                instr_valid = 1'b1;
                if (bus.Instr_ready) begin
                    handshake = 1'b1;
                    pc_ld_en  = 1'b1;
                    pc_sel    = bus.Branch_taken ? PC_SEL_BR : PC_SEL_SEQ;
                    if (halt_pend_q | bus.Halt) begin
                        state_d     = StHalted;
                        halt_pend_d = 1'b0;
                    end else begin
                        state_d  = StWait;
                        lat_load = 1'b1;
                    end
                end else begin
                    halt_pend_d = halt_pend_q | bus.Halt;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            ir_q        <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign bus.Instr_out   = ir_q;
    assign bus.Instr_valid = instr_valid;
    assign bus.PC_LdEn     = pc_ld_en;
    assign bus.PC_sel      = pc_sel;
    assign bus.Busy        = (state_q == StWait) || (state_q == StValid);

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

    // Saturating: stays at all-ones until the next reset.
    assign fetch_cnt_d = (handshake && (fetch_cnt_q != '1)) ? fetch_cnt_q + CNT_W'(1)
                                                            : fetch_cnt_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fetch_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign bus.Fetch_cnt = fetch_cnt_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule
